// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the CZNV flag register, resolves VeSPA branch
// conditions against it and issues a registered PC redirect plus a fixed-length flush.
module branch_cond_unit #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flags_we,
    input  logic              c_in,
    input  logic              z_in,
    input  logic              n_in,
    input  logic              v_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              resolved,
    output logic              taken,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              illegal_cond,
    output logic [3:0]        flags_out
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] flags;
    logic       accept;
    logic       ec, ez, en, ev;
    logic       base;
    logic       cond_taken;
    logic       cond_illegal;

    assign flags_out = flags;
    assign br_ready  = (state == IDLE);
    assign accept    = br_valid & br_ready;

    // Flags written in the accept cycle are forwarded into the evaluation.
    always_comb begin
        if (flags_we) {ec, ez, en, ev} = {c_in, z_in, n_in, v_in};
        else          {ec, ez, en, ev} = flags;
    end

    // Codes 1xxx are the complements of 0xxx, so only the base condition is decoded.
    always_comb begin
        base         = 1'b0;
        cond_illegal = 1'b0;
        case (br_cond[2:0])
            3'd0: base = 1'b1;
            3'd1: base = ~ec;
            3'd2: base = ~ev;
            3'd3: base = ez;
            3'd4: base = ~(en ^ ev);
            3'd5: base = ~ez & ~(en ^ ev);
            3'd6: base = ~en;
            3'd7: cond_illegal = 1'b1;
            default: base = 1'b0;
        endcase
        cond_taken = ~cond_illegal & (base ^ br_cond[3]);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        flush    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && cond_taken && (FLUSH_CYCLES > 0)) begin
                    state_nx = FLUSH;
                    cnt_nx   = FLUSH_INIT;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == 4'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags          <= '0;
            resolved       <= 1'b0;
            taken          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_cond   <= 1'b0;
        end else begin
            if (flags_we) flags <= {c_in, z_in, n_in, v_in};
            resolved       <= accept;
            illegal_cond   <= accept & cond_illegal;
            redirect_valid <= accept & cond_taken;
            if (accept) taken <= cond_taken;
            if (accept && cond_taken) redirect_pc <= br_target;
        end
    end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer side of the ALU condition-flag interface. Holds the architectural CZNV flag register, written from the ALU flag outputs.
- Evaluates VeSPA 4-bit branch condition codes against those flags and issues a registered PC redirect to fetch.
- After a taken branch it sequences a fixed-length pipeline flush.
- Sits between the ALU/execute stage and the fetch/PC logic of the CPU.

Parameters:
ADDR_W, 32, width of branch target and redirect PC.
FLUSH_CYCLES, 2, cycles flush is held high after a taken branch (legal range 0..15).

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  synchronous, active-high.
flags_we  in  1  latch c_in/z_in/n_in/v_in into flag register this cycle.
c_in  in  1  ALU carry flag.
z_in  in  1  ALU zero flag.
n_in  in  1  ALU negative flag.
v_in  in  1  ALU overflow flag.
br_valid  in  1  branch request valid.
br_ready  out  1  unit can accept a branch (combinational from state).
br_cond  in  4  condition code, sampled on accept.
br_target  in  ADDR_W  branch target, sampled on accept.
resolved  out  1  one-cycle pulse, a branch was evaluated.
taken  out  1  result of last evaluation, valid with resolved, held until the next resolved.
redirect_valid  out  1  one-cycle pulse, fetch must load redirect_pc.
redirect_pc  out  ADDR_W  registered target, held until next taken branch.
flush  out  1  high while pipeline bubbles are required.
illegal_cond  out  1  one-cycle pulse with resolved for a reserved code.
flags_out  out  4  {C,Z,N,V} current flag register.

Behaviour:
- Reset (synchronous): flags_out=0, resolved=0, taken=0, redirect_valid=0, redirect_pc=0, flush=0, illegal_cond=0, state=IDLE, flush counter=0.
- A reset asserted mid-flush aborts the flush and returns the unit to IDLE next edge.
- Flag register: on flags_we, {C,Z,N,V}<={c_in,z_in,n_in,v_in}; otherwise it holds. flags_we is honoured in every state.
- Effective flags for evaluation are the incoming c/z/n/v_in when flags_we=1 in the accept cycle (forwarding); otherwise they are the flag register.
- Condition table (cond -> taken):
  - 0000 -> 1 (BRA); 1000 -> 0 (BNV)
  - 0001 -> ~C (BCC); 1001 -> C (BCS)
  - 0010 -> ~V (BVC); 1010 -> V (BVS)
  - 0011 -> Z (BEQ); 1011 -> ~Z (BNE)
  - 0100 -> ~(N^V) (BGE); 1100 -> N^V (BLT)
  - 0101 -> ~Z&~(N^V) (BGT); 1101 -> Z|(N^V) (BLE)
  - 0110 -> ~N (BPL); 1110 -> N (BMI)
  - 0111, 1111 -> reserved: not taken, illegal_cond=1.
- Handshake: accept when br_valid & br_ready. br_ready=1 only in IDLE. A request held while br_ready=0 is accepted the first cycle it rises; no request is lost or duplicated.
- Latency: resolved, taken, illegal_cond and redirect_valid appear exactly 1 cycle after the accept edge.
- State machine has two states:
  - IDLE: on accept with taken=1 and FLUSH_CYCLES>0, go to FLUSH with counter=FLUSH_CYCLES. Otherwise stay in IDLE.
  - FLUSH: flush=1 and br_ready=0. The counter decrements each cycle; at counter==1 it returns to IDLE. flush is high for exactly FLUSH_CYCLES cycles, starting the same cycle as redirect_valid.
- FLUSH_CYCLES=0: no FLUSH state, flush is never asserted, and back-to-back branches are accepted every cycle.
- A not-taken branch never touches redirect_pc or flush.
- Outputs are pulses, not sticky, except taken, redirect_pc and flags_out.

Test Plan:
- Reset check: hold reset 2 cycles, then release -> all outputs 0, br_ready=1, flags_out=0000.
- Flag write and evaluation: flags_we with Z=1 (others 0), next cycle branch cond=0011 target=0x100 -> 1 cycle later resolved=1, taken=1, redirect_valid=1, redirect_pc=0x100; flush=1 for 2 cycles with br_ready=0; then br_ready=1.
- Forwarding: stored flags 0000; same cycle flags_we with N=1,V=0 and branch cond=1100 (BLT) -> taken=1. Repeat with cond=0100 -> taken=0, redirect_valid=0, flush=0.
- Full table sweep: all 16 codes × all 16 flag combinations -> taken matches the table. 0111 and 1111 give taken=0 and illegal_cond=1.
- Stall: br_valid held through a flush after a taken BRA to 0x200 -> second branch accepted on the first cycle br_ready=1 and evaluated exactly once.
- Reset mid-flush: reset asserted during the 1st flush cycle -> next cycle flush=0, br_ready=1, flags_out=0000, redirect_pc=0.
